// File: rtl/maquina_escritura_rtc_if.sv
// Bus bundle between the RTC write machine, the main machine and the bus control machine.
// Handshake: every input is sampled on the rising clk edge; the strobes are level-qualified one cycle at a time.
interface maquina_escritura_rtc_if;
  logic       DIR;
  logic       DAT;
  logic       cambio_estado;
  logic       Escritura;
  logic       En_clk;
  logic [7:0] D_Seg;
  logic [7:0] D_Min;
  logic [7:0] D_Hora;
  logic [7:0] Seg_E;
  logic [7:0] Min_E;
  logic [7:0] Hora_E;
  logic [7:0] Dia_E;
  logic [7:0] Mes_E;
  logic [7:0] Ano_E;
  logic [7:0] Dir_E;
  logic [7:0] Dato_E;
  logic       E_Esc;
  logic       Tr_Esc;
  logic       Term_Esc;

  modport master (
    output DIR, DAT, cambio_estado, Escritura, En_clk,
    output D_Seg, D_Min, D_Hora,
    output Seg_E, Min_E, Hora_E, Dia_E, Mes_E, Ano_E,
    input  Dir_E, Dato_E, E_Esc, Tr_Esc, Term_Esc
  );

  modport slave (
    input  DIR, DAT, cambio_estado, Escritura, En_clk,
    input  D_Seg, D_Min, D_Hora,
    input  Seg_E, Min_E, Hora_E, Dia_E, Mes_E, Ano_E,
    output Dir_E, Dato_E, E_Esc, Tr_Esc, Term_Esc
  );
endinterface

// File: rtl/maquina_escritura_rtc.sv
// RTC write sequencer: snapshots a time/date and walks the RTC registers one bus transaction each.
// Optional macro ESC_TIMER_EN enables the short timer-set path (En_clk = 0, command 8'hF2).
module maquina_escritura_rtc (
  input  logic                          clk,
  input  logic                          reset,
  maquina_escritura_rtc_if.slave        bus,
  output logic [2:0]                    state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_SEG  = 3'd1,
    W_MIN  = 3'd2,
    W_HORA = 3'd3,
    W_DIA  = 3'd4,
    W_MES  = 3'd5,
    W_ANO  = 3'd6,
    W_CMD  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic       e_esc_q, e_esc_d;
  logic       tr_esc_q, tr_esc_d;
  logic       term_esc;

  logic [7:0] seg_q, seg_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hora_q, hora_d;
  logic [7:0] dia_q, dia_d;
  logic [7:0] mes_q, mes_d;
  logic [7:0] ano_q, ano_d;
  logic       en_clk_q, en_clk_d;

  logic [7:0] cur_addr;
  logic [7:0] cur_data;
  state_t     next_w;

  // Per-state address/data and successor; RTC minute/second/hour addresses stay live.
  always_comb begin
    cur_addr = 8'hFF;
    cur_data = 8'h00;
    next_w   = IDLE;
    case (state_q)
      W_SEG: begin
        cur_addr = bus.D_Seg;
        cur_data = seg_q;
        next_w   = W_MIN;
      end
      W_MIN: begin
        cur_addr = bus.D_Min;
        cur_data = min_q;
        next_w   = W_HORA;
      end
      W_HORA: begin
        cur_addr = bus.D_Hora;
        cur_data = hora_q;
        next_w   = en_clk_q ? W_DIA : W_CMD;
      end
      W_DIA: begin
        cur_addr = 8'h24;
        cur_data = dia_q;
        next_w   = W_MES;
      end
      W_MES: begin
        cur_addr = 8'h25;
        cur_data = mes_q;
        next_w   = W_ANO;
      end
      W_ANO: begin
        cur_addr = 8'h26;
        cur_data = ano_q;
        next_w   = W_CMD;
      end
      W_CMD: begin
`ifdef ESC_TIMER_EN
        cur_addr = en_clk_q ? 8'hF1 : 8'hF2;
`else
        cur_addr = 8'hF1;
`endif
        cur_data = 8'h01;
        next_w   = IDLE;
      end
      default: begin
        cur_addr = 8'hFF;
        cur_data = 8'h00;
        next_w   = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
    e_esc_d  = e_esc_q;
    tr_esc_d = tr_esc_q;
    seg_d    = seg_q;
    min_d    = min_q;
    hora_d   = hora_q;
    dia_d    = dia_q;
    mes_d    = mes_q;
    ano_d    = ano_q;
    en_clk_d = en_clk_q;
    term_esc = 1'b0;

    case (state_q)
      IDLE: begin
        dir_d    = 8'hFF;
        dato_d   = 8'h00;
        e_esc_d  = 1'b0;
        tr_esc_d = 1'b0;
        if (bus.Escritura) begin
          seg_d    = bus.Seg_E;
          min_d    = bus.Min_E;
          hora_d   = bus.Hora_E;
          dia_d    = bus.Dia_E;
          mes_d    = bus.Mes_E;
          ano_d    = bus.Ano_E;
`ifdef ESC_TIMER_EN
          en_clk_d = bus.En_clk;
`else
          en_clk_d = 1'b1;
`endif
          e_esc_d  = 1'b1;
          state_d  = W_SEG;
        end
      end
      W_SEG, W_MIN, W_HORA, W_DIA, W_MES, W_ANO, W_CMD: begin
        // Strobe priority DIR > DAT > cambio_estado; an idle cycle keeps requesting.
        if (bus.DIR) begin
          dir_d = cur_addr;
        end else if (bus.DAT) begin
          dato_d   = cur_data;
          tr_esc_d = 1'b1;
        end else if (bus.cambio_estado) begin
          tr_esc_d = 1'b0;
          e_esc_d  = 1'b0;
          state_d  = next_w;
          term_esc = (state_q == W_CMD);
        end else begin
          e_esc_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        dir_d    = 8'hFF;
        dato_d   = 8'h00;
        e_esc_d  = 1'b0;
        tr_esc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= 8'hFF;
      dato_q   <= 8'h00;
      e_esc_q  <= 1'b0;
      tr_esc_q <= 1'b0;
      seg_q    <= 8'h00;
      min_q    <= 8'h00;
      hora_q   <= 8'h00;
      dia_q    <= 8'h00;
      mes_q    <= 8'h00;
      ano_q    <= 8'h00;
      en_clk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      e_esc_q  <= e_esc_d;
      tr_esc_q <= tr_esc_d;
      seg_q    <= seg_d;
      min_q    <= min_d;
      hora_q   <= hora_d;
      dia_q    <= dia_d;
      mes_q    <= mes_d;
      ano_q    <= ano_d;
      en_clk_q <= en_clk_d;
    end
  end

  // The done pulse is combinational, so reset must mask it to abort cleanly.
  assign bus.Term_Esc = term_esc & ~reset;
  assign bus.Dir_E    = dir_q;
  assign bus.Dato_E   = dato_q;
  assign bus.E_Esc    = e_esc_q;
  assign bus.Tr_Esc   = tr_esc_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_maquina_escritura_rtc.sv
// Directed bench for maquina_escritura_rtc: table of per-cycle strobes with expected bus outputs.
module tb_maquina_escritura_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  maquina_escritura_rtc_if bus ();

  maquina_escritura_rtc dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic       rst;
    logic       dir;
    logic       dat;
    logic       cmb;
    logic       esc;
    logic [7:0] seg;
    logic [7:0] exp_dir;
    logic [7:0] exp_dato;
    logic       exp_e;
    logic       exp_tr;
    logic       exp_term;
    logic [2:0] exp_state;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] seq_a[7];
  logic [7:0] seq_d[7];
  logic [2:0] seq_s[7];

  function automatic vec_t mkv(input logic rst, dir, dat, cmb, esc, input logic [7:0] seg,
                               input logic [7:0] ed, edt, input logic ee, etr, eterm,
                               input logic [2:0] est);
    vec_t v;
    v.rst = rst; v.dir = dir; v.dat = dat; v.cmb = cmb; v.esc = esc; v.seg = seg;
    v.exp_dir = ed; v.exp_dato = edt; v.exp_e = ee; v.exp_tr = etr;
    v.exp_term = eterm; v.exp_state = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full write from IDLE using seq_* tables; abort_last replaces the final cambio with a reset.
  task automatic add_write(input int n, input bit abort_last);
    logic [7:0] cur_dato;
    logic       cur_e;
    cur_dato = 8'h00;
    cur_e    = 1'b1;
    q.push_back(mkv(0, 0, 0, 0, 1, 8'h45, 8'hFF, 8'h00, 1, 0, 0, 3'd1));
    for (int i = 0; i < n; i++) begin
      q.push_back(mkv(0, 1, 0, 0, 0, 8'h45, seq_a[i], cur_dato, cur_e, 0, 0, seq_s[i]));
      cur_dato = seq_d[i];
      q.push_back(mkv(0, 0, 1, 0, 0, 8'h45, seq_a[i], cur_dato, cur_e, 1, 0, seq_s[i]));
      if (abort_last && i == n - 1)
        q.push_back(mkv(1, 0, 0, 1, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
      else
        q.push_back(mkv(0, 0, 0, 1, 0, 8'h45, seq_a[i], cur_dato, 0, 0, (i == n - 1),
                        (i == n - 1) ? 3'd0 : seq_s[i + 1]));
      cur_e = 1'b0;
    end
    q.push_back(mkv(0, 0, 0, 0, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
  endtask

  task automatic apply_all(input string tag);
    foreach (q[i]) begin
      @(negedge clk);
      reset             = q[i].rst;
      bus.DIR           = q[i].dir;
      bus.DAT           = q[i].dat;
      bus.cambio_estado = q[i].cmb;
      bus.Escritura     = q[i].esc;
      bus.Seg_E         = q[i].seg;
      #1;
      chk($sformatf("%s[%0d] term_esc", tag, i), {7'b0, bus.Term_Esc}, {7'b0, q[i].exp_term});
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d] dir_e", tag, i), bus.Dir_E, q[i].exp_dir);
      chk($sformatf("%s[%0d] dato_e", tag, i), bus.Dato_E, q[i].exp_dato);
      chk($sformatf("%s[%0d] e_esc", tag, i), {7'b0, bus.E_Esc}, {7'b0, q[i].exp_e});
      chk($sformatf("%s[%0d] tr_esc", tag, i), {7'b0, bus.Tr_Esc}, {7'b0, q[i].exp_tr});
      chk($sformatf("%s[%0d] state", tag, i), {5'b0, state_dbg}, {5'b0, q[i].exp_state});
    end
    q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.DIR = 1'b0; bus.DAT = 1'b0; bus.cambio_estado = 1'b0; bus.Escritura = 1'b0;
    bus.En_clk = 1'b1;
    bus.D_Seg = 8'h21; bus.D_Min = 8'h22; bus.D_Hora = 8'h23;
    bus.Seg_E = 8'h45; bus.Min_E = 8'h30; bus.Hora_E = 8'h12;
    bus.Dia_E = 8'h15; bus.Mes_E = 8'h08; bus.Ano_E = 8'h16;

    // Reset state, with Escritura held to show reset wins.
    q.push_back(mkv(1, 0, 0, 0, 1, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
    q.push_back(mkv(1, 1, 1, 1, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
    apply_all("reset");

    // Clock write.
    seq_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1};
    seq_d = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h16, 8'h01};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    add_write(7, 1'b0);
    apply_all("clock");

    // DIR and DAT together: address only.
    q.push_back(mkv(0, 0, 0, 0, 1, 8'h45, 8'hFF, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(0, 1, 1, 0, 0, 8'h45, 8'h21, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(1, 0, 0, 0, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
    apply_all("prio");

    // Snapshot isolation and Escritura ignored outside IDLE.
    q.push_back(mkv(0, 0, 0, 0, 1, 8'h45, 8'hFF, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(0, 1, 0, 0, 0, 8'h59, 8'h21, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(0, 0, 1, 0, 0, 8'h59, 8'h21, 8'h45, 1, 1, 0, 3'd1));
    q.push_back(mkv(0, 0, 0, 1, 0, 8'h59, 8'h21, 8'h45, 0, 0, 0, 3'd2));
    q.push_back(mkv(0, 0, 0, 0, 1, 8'h59, 8'h21, 8'h45, 1, 0, 0, 3'd2));
    q.push_back(mkv(0, 1, 0, 0, 0, 8'h59, 8'h22, 8'h45, 1, 0, 0, 3'd2));
    q.push_back(mkv(0, 0, 1, 0, 0, 8'h59, 8'h22, 8'h30, 1, 1, 0, 3'd2));
    q.push_back(mkv(1, 0, 0, 0, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
    apply_all("snap");

    // Reset in W_HORA (with cambio_estado high), then a fresh start.
    seq_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1};
    seq_d = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h16, 8'h01};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    add_write(3, 1'b1);
    void'(q.pop_back());
    q.push_back(mkv(0, 0, 0, 0, 1, 8'h45, 8'hFF, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(0, 1, 0, 0, 0, 8'h45, 8'h21, 8'h00, 1, 0, 0, 3'd1));
    q.push_back(mkv(1, 0, 0, 0, 0, 8'h45, 8'hFF, 8'h00, 0, 0, 0, 3'd0));
    apply_all("rst_hora");

    // Timer write request.
    bus.En_clk = 1'b0;
    bus.D_Seg = 8'h41; bus.D_Min = 8'h42; bus.D_Hora = 8'h43;
`ifdef ESC_TIMER_EN
    seq_a = '{8'h41, 8'h42, 8'h43, 8'hF2, 8'h00, 8'h00, 8'h00};
    seq_d = '{8'h45, 8'h30, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0};
    add_write(4, 1'b0);
`else
    seq_a = '{8'h41, 8'h42, 8'h43, 8'h24, 8'h25, 8'h26, 8'hF1};
    seq_d = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h16, 8'h01};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    add_write(7, 1'b0);
`endif
    apply_all("timer");

    // Reset together with cambio_estado in W_CMD: no done pulse.
    bus.En_clk = 1'b1;
    bus.D_Seg = 8'h21; bus.D_Min = 8'h22; bus.D_Hora = 8'h23;
    seq_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1};
    seq_d = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h16, 8'h01};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    add_write(7, 1'b1);
    apply_all("rst_cmd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
